// File: rtl/score_keeper.sv
// score_keeper -- frame-tick driven BCD score counter with optional high score.
//
// Counts one score point every TICKS_PER_POINT frame ticks while a run is
// active, ends the run on a collision pulse and optionally keeps a high score.
//
// Parameters:
//   TICKS_PER_POINT  frame ticks per score point (1..255, default 6)
//
// Ports:
//   clk                      system clock (shared with the VGA block)
//   reset                    synchronous active-high reset
//   tick                     one-cycle frame pulse
//   start                    one-cycle request to begin/restart a run
//   hit                      one-cycle collision pulse
//   score_d2/d1/d0           current score, BCD, d2 = hundreds
//   hi_d2/d1/d0              high score, BCD
//   score_upd                one-cycle pulse when any score/hi digit changed
//   running                  high while a run is active
//   game_over                high after a run has ended
//
// Configuration:
//   SCORE_KEEPER_HISCORE_EN  when defined, a high score register is loaded at
//                            the end of a run if the run's score beats it.
//                            When undefined, hi_d2..hi_d0 are constant 0.

module score_keeper #(
    parameter int TICKS_PER_POINT = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       hit,
    output logic [3:0] score_d2,
    output logic [3:0] score_d1,
    output logic [3:0] score_d0,
    output logic [3:0] hi_d2,
    output logic [3:0] hi_d1,
    output logic [3:0] hi_d0,
    output logic       score_upd,
    output logic       running,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [7:0] PRESCALE_MAX = 8'(TICKS_PER_POINT - 1);

    state_t     state;
    logic [7:0] prescaler;

    // Next-score values for a BCD increment with ripple carry.
    logic [3:0] inc_d2;
    logic [3:0] inc_d1;
    logic [3:0] inc_d0;
    logic       score_at_max;
    logic       score_nonzero;
    logic       point_due;

    always_comb begin
        inc_d0 = score_d0;
        inc_d1 = score_d1;
        inc_d2 = score_d2;
        if (score_d0 == 4'd9) begin
            inc_d0 = 4'd0;
            if (score_d1 == 4'd9) begin
                inc_d1 = 4'd0;
                inc_d2 = score_d2 + 4'd1;
            end else begin
                inc_d1 = score_d1 + 4'd1;
            end
        end else begin
            inc_d0 = score_d0 + 4'd1;
        end
    end

    assign score_at_max  = (score_d2 == 4'd9) && (score_d1 == 4'd9) && (score_d0 == 4'd9);
    assign score_nonzero = (score_d2 != 4'd0) || (score_d1 != 4'd0) || (score_d0 != 4'd0);
    assign point_due     = (prescaler == PRESCALE_MAX);

`ifdef SCORE_KEEPER_HISCORE_EN
    // BCD digits compare correctly as a packed 12-bit value since each
    // digit is bounded to 0..9.
    logic score_beats_hi;
    assign score_beats_hi = {score_d2, score_d1, score_d0} > {hi_d2, hi_d1, hi_d0};
`else
    assign hi_d2 = '0;
    assign hi_d1 = '0;
    assign hi_d0 = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prescaler <= '0;
            score_d2  <= '0;
            score_d1  <= '0;
            score_d0  <= '0;
            score_upd <= 1'b0;
            running   <= 1'b0;
            game_over <= 1'b0;
`ifdef SCORE_KEEPER_HISCORE_EN
            hi_d2     <= '0;
            hi_d1     <= '0;
            hi_d0     <= '0;
`endif
        end else begin
            score_upd <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    // start wins over any coincident tick or hit here
                    if (start) begin
                        state     <= RUN;
                        running   <= 1'b1;
                        game_over <= 1'b0;
                        prescaler <= '0;
                        score_d2  <= '0;
                        score_d1  <= '0;
                        score_d0  <= '0;
                        score_upd <= score_nonzero;
                    end
                end

                RUN: begin
                    // hit has priority over tick; start is ignored in RUN
                    if (hit) begin
                        state     <= OVER;
                        running   <= 1'b0;
                        game_over <= 1'b1;
`ifdef SCORE_KEEPER_HISCORE_EN
                        if (score_beats_hi) begin
                            hi_d2     <= score_d2;
                            hi_d1     <= score_d1;
                            hi_d0     <= score_d0;
                            score_upd <= 1'b1;
                        end
`endif
                    end else if (tick) begin
                        if (point_due) begin
                            prescaler <= '0;
                            if (!score_at_max) begin
                                score_d2  <= inc_d2;
                                score_d1  <= inc_d1;
                                score_d0  <= inc_d0;
                                score_upd <= 1'b1;
                            end
                        end else begin
                            prescaler <= prescaler + 8'd1;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    running   <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

endmodule
